// File: rtl/mig_stub_pkg.sv
// Shared command encodings and address helpers for the MIG app-interface BRAM stub.
package mig_stub_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // Cycles between a sampled maintenance request edge and its ack pulse.
  localparam int ACK_DELAY = 4;

  // One BL8 burst covers 8 app addresses; higher bits beyond the RAM depth wrap.
  function automatic logic [31:0] word_index(input logic [63:0] addr, input int depth_log2);
    logic [63:0] idx;
    idx = (addr >> 3) & ((64'd1 << depth_log2) - 64'd1);
    return idx[31:0];
  endfunction

endpackage

// File: rtl/stub_sync_fifo.sv
// Single-clock FIFO with a registered occupancy count; head word is shown combinationally.
module stub_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mig_app_bram_stub.sv
// Block-RAM backed stand-in for a MIG DDR3 controller: queues app commands and write
// data, executes them in order, returns reads with fixed latency, emulates maintenance acks.
module mig_app_bram_stub
  import mig_stub_pkg::*;
#(
  parameter int ADDR_WIDTH    = 30,
  parameter int MEM_DATA_BITS = 256,
  parameter int MASK_WIDTH    = 32,
  parameter int DEPTH_LOG2    = 10,
  parameter int RD_LATENCY    = 8,
  parameter int INIT_CYCLES   = 64,
  parameter int STALL_PERIOD  = 0,
  parameter int QDEPTH_LOG2   = 2
) (
  input  logic                     ddr_clk_i,
  input  logic                     ddr_rst_i,
  output logic                     local_init_done_o,
  input  logic [ADDR_WIDTH-1:0]    app_addr,
  input  logic [2:0]               app_cmd,
  input  logic                     app_en,
  output logic                     app_rdy,
  input  logic [MEM_DATA_BITS-1:0] app_wdf_data,
  input  logic [MASK_WIDTH-1:0]    app_wdf_mask,
  input  logic                     app_wdf_wren,
  input  logic                     app_wdf_end,
  output logic                     app_wdf_rdy,
  output logic [MEM_DATA_BITS-1:0] app_rd_data,
  output logic                     app_rd_data_valid,
  output logic                     app_rd_data_end,
  input  logic                     app_ref_req,
  input  logic                     app_zq_req,
  input  logic                     app_sr_req,
  output logic                     app_ref_ack,
  output logic                     app_zq_ack,
  output logic                     app_sr_active,
  output logic [31:0]              wr_cnt_o,
  output logic [31:0]              rd_cnt_o,
  output logic                     err_cmd_o
);
  localparam int CQ_W  = 3 + ADDR_WIDTH;
  localparam int DQ_W  = MEM_DATA_BITS + MASK_WIDTH;
  localparam int SP    = (STALL_PERIOD == 0) ? 1 : STALL_PERIOD;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]              init_cnt_q;
  logic                     init_done_q;
  logic [15:0]              stall_cnt_q;
  logic                     stall;
  logic                     cq_push, cq_pop, cq_full, cq_empty;
  logic                     dq_push, dq_pop, dq_full, dq_empty;
  logic [CQ_W-1:0]          cq_head;
  logic [DQ_W-1:0]          dq_head;
  logic [2:0]               head_cmd;
  logic [ADDR_WIDTH-1:0]    head_addr;
  logic [MEM_DATA_BITS-1:0] head_data;
  logic [MASK_WIDTH-1:0]    head_mask;
  logic [DEPTH_LOG2-1:0]    ram_idx;
  logic                     exec_wr, exec_rd, exec_bad;
  logic [MEM_DATA_BITS-1:0] mem_q [DEPTH];
  logic [MEM_DATA_BITS-1:0] rd_pipe_q [RD_LATENCY];
  logic [RD_LATENCY-1:0]    rd_vld_q;
  logic                     rd_valid_q;
  logic [MEM_DATA_BITS-1:0] rd_data_q;
  logic [31:0]              wr_cnt_q, rd_cnt_q;
  logic                     err_q;
  logic [1:0]               ref_req_q, zq_req_q;
  logic [ACK_DELAY-1:0]     ref_sh_q, zq_sh_q;
  logic                     sr_q;
  logic                     unused_bits;

  assign unused_bits = app_wdf_end;

  // Ready depends only on registered state, never on app_en/app_cmd.
  assign stall       = (STALL_PERIOD != 0) && (stall_cnt_q == 16'(SP - 1));
  assign app_rdy     = init_done_q & ~cq_full & ~stall;
  assign app_wdf_rdy = init_done_q & ~dq_full;
  assign cq_push     = app_en & app_rdy;
  assign dq_push     = app_wdf_wren & app_wdf_rdy;

  stub_sync_fifo #(.WIDTH(CQ_W), .DEPTH_LOG2(QDEPTH_LOG2)) u_cmd_q (
    .clk_i(ddr_clk_i), .rst_i(ddr_rst_i), .push_i(cq_push), .pop_i(cq_pop),
    .data_i({app_cmd, app_addr}), .data_o(cq_head), .full_o(cq_full), .empty_o(cq_empty)
  );

  stub_sync_fifo #(.WIDTH(DQ_W), .DEPTH_LOG2(QDEPTH_LOG2)) u_data_q (
    .clk_i(ddr_clk_i), .rst_i(ddr_rst_i), .push_i(dq_push), .pop_i(dq_pop),
    .data_i({app_wdf_data, app_wdf_mask}), .data_o(dq_head), .full_o(dq_full), .empty_o(dq_empty)
  );

  assign head_cmd  = cq_head[CQ_W-1 -: 3];
  assign head_addr = cq_head[ADDR_WIDTH-1:0];
  assign head_data = dq_head[DQ_W-1 -: MEM_DATA_BITS];
  assign head_mask = dq_head[MASK_WIDTH-1:0];
  assign ram_idx   = DEPTH_LOG2'(word_index(64'(head_addr), DEPTH_LOG2));

  // A write at the head waits for its data; reads and illegal commands never stall.
  always_comb begin
    exec_wr  = 1'b0;
    exec_rd  = 1'b0;
    exec_bad = 1'b0;
    if (!cq_empty) begin
      if (head_cmd == CMD_WRITE)     exec_wr  = ~dq_empty;
      else if (head_cmd == CMD_READ) exec_rd  = 1'b1;
      else                           exec_bad = 1'b1;
    end
  end

  assign cq_pop = exec_wr | exec_rd | exec_bad;
  assign dq_pop = exec_wr;

  always_ff @(posedge ddr_clk_i) begin
    if (exec_wr) begin
      for (int b = 0; b < MASK_WIDTH; b++) begin
        if (!head_mask[b]) mem_q[ram_idx][b*8 +: 8] <= head_data[b*8 +: 8];
      end
    end
    if (exec_rd) rd_pipe_q[0] <= mem_q[ram_idx];
    for (int i = 1; i < RD_LATENCY; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
  end

  always_ff @(posedge ddr_clk_i or posedge ddr_rst_i) begin
    if (ddr_rst_i) begin
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      stall_cnt_q <= '0;
      rd_vld_q    <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      err_q       <= 1'b0;
      ref_req_q   <= '0;
      zq_req_q    <= '0;
      ref_sh_q    <= '0;
      zq_sh_q     <= '0;
      sr_q        <= 1'b0;
    end else begin
      if (!init_done_q) begin
        init_cnt_q  <= init_cnt_q + 32'd1;
        init_done_q <= (init_cnt_q == 32'(INIT_CYCLES - 1));
      end
      stall_cnt_q <= (stall_cnt_q == 16'(SP - 1)) ? '0 : stall_cnt_q + 16'd1;
      // Valid bit travels beside the read data; output register is stage RD_LATENCY.
      rd_vld_q   <= {rd_vld_q[RD_LATENCY-2:0], exec_rd};
      rd_valid_q <= rd_vld_q[RD_LATENCY-1];
      if (rd_vld_q[RD_LATENCY-1]) rd_data_q <= rd_pipe_q[RD_LATENCY-1];
      if (exec_wr)  wr_cnt_q <= wr_cnt_q + 32'd1;
      if (exec_rd)  rd_cnt_q <= rd_cnt_q + 32'd1;
      if (exec_bad) err_q <= 1'b1;
      ref_req_q <= {ref_req_q[0], app_ref_req};
      zq_req_q  <= {zq_req_q[0], app_zq_req};
      ref_sh_q  <= {ref_sh_q[ACK_DELAY-2:0], ref_req_q[0] & ~ref_req_q[1]};
      zq_sh_q   <= {zq_sh_q[ACK_DELAY-2:0], zq_req_q[0] & ~zq_req_q[1]};
      sr_q      <= app_sr_req;
    end
  end

  assign local_init_done_o = init_done_q;
  assign app_rd_data       = rd_data_q;
  assign app_rd_data_valid = rd_valid_q;
  assign app_rd_data_end   = rd_valid_q;
  assign app_ref_ack       = ref_sh_q[ACK_DELAY-1];
  assign app_zq_ack        = zq_sh_q[ACK_DELAY-1];
  assign app_sr_active     = sr_q;
  assign wr_cnt_o          = wr_cnt_q;
  assign rd_cnt_o          = rd_cnt_q;
  assign err_cmd_o         = err_q;

endmodule

// File: tb/tb_mig_app_bram_stub.sv
// Directed bench for mig_app_bram_stub: one default instance and one with STALL_PERIOD=3.
module tb_mig_app_bram_stub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [255:0] wdf_data;
  logic [31:0]  wdf_mask;
  logic         ref_req, zq_req, sr_req;

  logic [29:0]  a_addr, b_addr;
  logic [2:0]   a_cmd, b_cmd;
  logic         a_en, b_en, a_wren, b_wren;

  logic         a_done, a_rdy, a_wrdy, a_vld, a_end, a_rack, a_zack, a_sr, a_err;
  logic [255:0] a_data;
  logic [31:0]  a_wcnt, a_rcnt;
  logic         b_done, b_rdy, b_wrdy, b_vld, b_end, b_rack, b_zack, b_sr, b_err;
  logic [255:0] b_data;
  logic [31:0]  b_wcnt, b_rcnt;

  mig_app_bram_stub u_dut (
    .ddr_clk_i(clk), .ddr_rst_i(rst), .local_init_done_o(a_done),
    .app_addr(a_addr), .app_cmd(a_cmd), .app_en(a_en), .app_rdy(a_rdy),
    .app_wdf_data(wdf_data), .app_wdf_mask(wdf_mask), .app_wdf_wren(a_wren),
    .app_wdf_end(1'b1), .app_wdf_rdy(a_wrdy),
    .app_rd_data(a_data), .app_rd_data_valid(a_vld), .app_rd_data_end(a_end),
    .app_ref_req(ref_req), .app_zq_req(zq_req), .app_sr_req(sr_req),
    .app_ref_ack(a_rack), .app_zq_ack(a_zack), .app_sr_active(a_sr),
    .wr_cnt_o(a_wcnt), .rd_cnt_o(a_rcnt), .err_cmd_o(a_err)
  );

  mig_app_bram_stub #(.STALL_PERIOD(3)) u_dut_stall (
    .ddr_clk_i(clk), .ddr_rst_i(rst), .local_init_done_o(b_done),
    .app_addr(b_addr), .app_cmd(b_cmd), .app_en(b_en), .app_rdy(b_rdy),
    .app_wdf_data(wdf_data), .app_wdf_mask(wdf_mask), .app_wdf_wren(b_wren),
    .app_wdf_end(1'b1), .app_wdf_rdy(b_wrdy),
    .app_rd_data(b_data), .app_rd_data_valid(b_vld), .app_rd_data_end(b_end),
    .app_ref_req(ref_req), .app_zq_req(zq_req), .app_sr_req(sr_req),
    .app_ref_ack(b_rack), .app_zq_ack(b_zack), .app_sr_active(b_sr),
    .wr_cnt_o(b_wcnt), .rd_cnt_o(b_rcnt), .err_cmd_o(b_err)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called and returns at a negedge; holds the command until an edge sees rdy high.
  task automatic push_cmd(input bit b, input logic [2:0] c, input logic [29:0] a);
    bit acc = 1'b0;
    int n = 0;
    if (b) begin b_en = 1'b1; b_cmd = c; b_addr = a; end
    else   begin a_en = 1'b1; a_cmd = c; a_addr = a; end
    while (!acc && n < 200) begin
      acc = b ? b_rdy : a_rdy;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (b) b_en = 1'b0; else a_en = 1'b0;
    if (!acc) check("cmd_timeout", 256'(acc), 256'(1));
  endtask

  task automatic push_data(input bit b, input logic [255:0] d, input logic [31:0] m);
    bit acc = 1'b0;
    int n = 0;
    wdf_data = d;
    wdf_mask = m;
    if (b) b_wren = 1'b1; else a_wren = 1'b1;
    while (!acc && n < 200) begin
      acc = b ? b_wrdy : a_wrdy;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (b) b_wren = 1'b0; else a_wren = 1'b0;
    if (!acc) check("data_timeout", 256'(acc), 256'(1));
  endtask

  task automatic write_a(input logic [29:0] a, input logic [255:0] d, input logic [31:0] m);
    fork
      push_cmd(1'b0, 3'b000, a);
      push_data(1'b0, d, m);
    join
  endtask

  // Read on the default instance; valid is expected exactly 9 cycles after acceptance.
  task automatic read_check(input logic [29:0] a, input logic [255:0] exp, input string tag);
    int k = 0;
    push_cmd(1'b0, 3'b001, a);
    while (!a_vld && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, 256'(k), 256'(9));
    check({tag, "_data"}, a_data, exp);
    check({tag, "_end"}, 256'(a_end), 256'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, got, zeros, vseen, acks_r, acks_z;
    a_en = 0; b_en = 0; a_wren = 0; b_wren = 0;
    a_cmd = 0; b_cmd = 0; a_addr = 0; b_addr = 0;
    wdf_data = '0; wdf_mask = '0;
    ref_req = 0; zq_req = 0; sr_req = 0;

    repeat (3) @(negedge clk);
    check("rst_done", 256'(a_done), 256'(0));
    check("rst_rdy", 256'(a_rdy), 256'(0));
    check("rst_wrdy", 256'(a_wrdy), 256'(0));
    check("rst_vld", 256'(a_vld), 256'(0));
    check("rst_data", a_data, 256'(0));
    check("rst_wcnt", 256'(a_wcnt), 256'(0));
    rst = 1'b0;

    n = 0;
    while (cyc < 63 && n < 200) begin @(negedge clk); n++; end
    check("init_63", 256'(a_done), 256'(0));
    @(negedge clk);
    check("init_64", 256'(a_done), 256'(1));
    check("init_rdy", 256'(a_rdy), 256'(1));
    check("init_wrdy", 256'(a_wrdy), 256'(1));

    // Same-cycle command and data, then readback.
    write_a(30'h10, {32{8'hA5}}, 32'h0);
    read_check(30'h10, {32{8'hA5}}, "t1");
    check("t1_wcnt", 256'(a_wcnt), 256'(1));
    check("t1_rcnt", 256'(a_rcnt), 256'(1));

    // Data three cycles ahead of its command; only byte 0 unmasked.
    write_a(30'h20, 256'(0), 32'h0);
    push_data(1'b0, {32{8'h5A}}, 32'hFFFF_FFFE);
    repeat (3) @(negedge clk);
    push_cmd(1'b0, 3'b000, 30'h20);
    read_check(30'h20, 256'h5A, "t2");

    // Eight write commands with data held back: queue fills after four.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          push_cmd(1'b0, 3'b000, 30'(32'h40 + i * 8));
          if (i == 3) begin
            check("t3_full_rdy", 256'(a_rdy), 256'(0));
            check("t3_wcnt_hold", 256'(a_wcnt), 256'(3));
          end
        end
      end
      begin
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) push_data(1'b0, {32{8'(8'h80 + i)}}, 32'h0);
      end
    join
    repeat (3) @(negedge clk);
    read_check(30'h78, {32{8'h87}}, "t3_last");
    read_check(30'h40, {32{8'h80}}, "t3_first");
    check("t3_wcnt", 256'(a_wcnt), 256'(11));

    // Stalling instance: preload eight words, then stream reads of 0x0..0x38.
    for (int i = 0; i < 8; i++) begin
      fork
        push_cmd(1'b1, 3'b000, 30'(i * 8));
        push_data(1'b1, {16{16'(16'hB000 + i)}}, 32'h0);
      join
    end
    repeat (3) @(negedge clk);
    got = 0; zeros = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) push_cmd(1'b1, 3'b001, 30'(i * 8));
      end
      begin
        for (int j = 0; j < 12; j++) begin
          check("stall_rdy", 256'(b_rdy), 256'((cyc % 3) != 2));
          if (!b_rdy) zeros++;
          @(negedge clk);
        end
      end
      begin
        n = 0;
        while (got < 8 && n < 300) begin
          if (b_vld) begin
            check("stall_data", b_data, {16{16'(16'hB000 + got)}});
            check("stall_end", 256'(b_end), 256'(1));
            got++;
          end
          @(negedge clk);
          n++;
        end
      end
    join
    check("stall_count", 256'(got), 256'(8));
    check("stall_seen", 256'(zeros >= 3), 256'(1));
    check("stall_rcnt", 256'(b_rcnt), 256'(8));

    // Reset with reads in flight.
    for (int i = 0; i < 3; i++) push_cmd(1'b0, 3'b001, 30'(i * 8));
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_vld", 256'(a_vld), 256'(0));
    check("mid_rst_done", 256'(a_done), 256'(0));
    check("mid_rst_wcnt", 256'(a_wcnt), 256'(0));
    check("mid_rst_rcnt", 256'(a_rcnt), 256'(0));
    rst = 1'b0;
    vseen = 0;
    for (int j = 0; j < 80; j++) begin
      if (a_vld) vseen++;
      @(negedge clk);
    end
    check("mid_rst_novld", 256'(vseen), 256'(0));
    check("mid_rst_init", 256'(a_done), 256'(1));

    // Illegal command sets the sticky error.
    check("err_before", 256'(a_err), 256'(0));
    push_cmd(1'b0, 3'b111, 30'h0);
    @(negedge clk);
    check("err_after", 256'(a_err), 256'(1));
    repeat (3) @(negedge clk);
    check("err_sticky", 256'(a_err), 256'(1));

    // Maintenance: requests held high ack once, four cycles after sampling.
    ref_req = 1'b1; zq_req = 1'b1; sr_req = 1'b1;
    acks_r = 0; acks_z = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (j == 0) check("sr_active", 256'(a_sr), 256'(1));
      if (j == 4) begin
        check("ref_ack_t4", 256'(a_rack), 256'(1));
        check("zq_ack_t4", 256'(a_zack), 256'(1));
      end
      if (a_rack) acks_r++;
      if (a_zack) acks_z++;
    end
    check("ref_ack_once", 256'(acks_r), 256'(1));
    check("zq_ack_once", 256'(acks_z), 256'(1));
    sr_req = 1'b0;
    @(negedge clk);
    check("sr_clear", 256'(a_sr), 256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
